// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl_pkg: shared encodings for the
// accumulator register controller.
package acc_ctrl_pkg;

  localparam int ACC_WIDTH = 34;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_reg_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick,
// first request at or above ptr, modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      grant_idx,
  output logic            any
);

  logic [2*NREQ-1:0] rot;
  logic [3:0]        sum;

  assign rot = {req, req} >> ptr;

  // scan downward so the lowest offset from ptr wins
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + 4'(k);
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        grant_idx = sum[2:0];
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_reg_ctrl.sv
// acc_reg_ctrl: arbitrates requesters onto one
// external accumulator register (no enable, no reset).
module acc_reg_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic                  C,
  input  logic                  Rn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic [WIDTH-1:0]      reg_q,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic [2:0]            rd_src,
  output logic                  busy
);

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       g;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;

  logic [2:0]       gnt;
  logic             any;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] nxt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant_idx (gnt),
    .any       (any)
  );

  // pick the winning requester's op and operand
  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == 3'(i)) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  // register next value: hold unless executing
  always_comb begin
    nxt = reg_q;
    if (state == ST_EXEC) begin
      unique case (op_r)
        OP_LOAD:  nxt = data_r;
        OP_ADD:   nxt = reg_q + data_r;
        OP_CLEAR: nxt = '0;
        OP_READ:  nxt = reg_q;
        default:  nxt = reg_q;
      endcase
    end
  end

  // register captures zero on every edge in reset
  assign reg_d = Rn ? nxt : '0;

  // control FSM with registered handshake outputs
  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      g         <= '0;
      op_r      <= '0;
      data_r    <= '0;
      req_ready <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_src    <= '0;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_src    <= '0;
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            state  <= ST_EXEC;
            g      <= gnt;
            op_r   <= sel_op;
            data_r <= sel_data;
            ptr    <= (gnt == 3'(NREQ - 1)) ? 3'd0 : gnt + 3'd1;
            busy   <= 1'b1;
          end
        end
        ST_EXEC: begin
          state     <= ST_ACK;
          req_ready <= NREQ'(1) << g;
          rd_valid  <= 1'b1;
          rd_data   <= nxt;
          rd_src    <= g;
        end
        ST_ACK: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_reg_ctrl.sv
// tb_acc_reg_ctrl: directed checks of the accumulator
// controller driving a behavioural 34-bit register.
module tb_acc_reg_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 34;

  logic                  C = 1'b0;
  logic                  Rn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [2*NREQ-1:0]     req_op = '0;
  logic [WIDTH*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      reg_q;
  logic [WIDTH-1:0]      reg_d;
  logic                  rd_valid;
  logic [WIDTH-1:0]      rd_data;
  logic [2:0]            rd_src;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  acc_reg_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .C         (C),
    .Rn        (Rn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_q     (reg_q),
    .reg_d     (reg_d),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_src    (rd_src),
    .busy      (busy)
  );

  always #5 C = ~C;

  // stand-in for d_flip_flop34b
  always @(posedge C) reg_q <= reg_d;

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [1:0] op,
                         input logic [WIDTH-1:0] data);
    req_valid[idx]            = 1'b1;
    req_op[2*idx +: 2]        = op;
    req_data[WIDTH*idx +: WIDTH] = data;
  endtask

  // one full operation from a lone requester
  task automatic do_op(input string tag, input int idx,
                       input logic [1:0] op,
                       input logic [WIDTH-1:0] data,
                       input logic [WIDTH-1:0] exp);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    set_req(idx, op, data);
    step();
    chk({tag, ".exec_busy"}, WIDTH'(busy), WIDTH'(1));
    chk({tag, ".exec_rdy"}, WIDTH'(req_ready), '0);
    chk({tag, ".exec_regd"}, reg_d, exp);
    step();
    chk({tag, ".ack_rdy"}, WIDTH'(req_ready), WIDTH'(oh));
    chk({tag, ".ack_vld"}, WIDTH'(rd_valid), WIDTH'(1));
    chk({tag, ".ack_data"}, rd_data, exp);
    chk({tag, ".ack_src"}, WIDTH'(rd_src), WIDTH'(idx));
    chk({tag, ".ack_regq"}, reg_q, exp);
    req_valid[idx] = 1'b0;
    step();
    chk({tag, ".idle_vld"}, WIDTH'(rd_valid), '0);
    chk({tag, ".idle_data"}, rd_data, '0);
    chk({tag, ".idle_busy"}, WIDTH'(busy), '0);
  endtask

  initial begin
    // reset held across two edges
    Rn = 1'b0;
    #1;
    chk("rst.regd", reg_d, '0);
    step();
    step();
    chk("rst.regq", reg_q, '0);
    chk("rst.rdy", WIDTH'(req_ready), '0);
    chk("rst.vld", WIDTH'(rd_valid), '0);
    chk("rst.data", rd_data, '0);
    chk("rst.src", WIDTH'(rd_src), '0);
    chk("rst.busy", WIDTH'(busy), '0);
    Rn = 1'b1;

    // read after reset, req0 (ptr -> 1)
    do_op("read0", 0, 2'b11, '0, '0);

    // load then add from req1 (ptr -> 2)
    do_op("load5", 1, 2'b00, 34'h5, 34'h5);
    do_op("add3", 1, 2'b01, 34'h3, 34'h8);

    // wrap from req3 (ptr -> 0)
    do_op("loadmax", 3, 2'b00, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF);
    do_op("addwrap", 3, 2'b01, 34'h1, 34'h0);

    // round-robin, all READ held
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b11, 34'h77);
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      logic [NREQ-1:0] oh;
      step();
      step();
      for (int n = 0; n < 5; n++) begin
        oh = '0;
        oh[order[n]] = 1'b1;
        chk("rr.src", WIDTH'(rd_src), WIDTH'(order[n]));
        chk("rr.rdy", WIDTH'(req_ready), WIDTH'(oh));
        chk("rr.data", rd_data, '0);
        if (n < 4) begin
          step();
          chk("rr.gap", WIDTH'(rd_valid), '0);
          step();
          chk("rr.gap2", WIDTH'(rd_valid), '0);
          step();
        end
      end
    end
    req_valid = '0;
    step();

    // req1 -> ptr 2, then req2 load -> ptr 3
    do_op("pre1", 1, 2'b11, '0, '0);
    do_op("pre2", 2, 2'b00, 34'h55, 34'h55);

    // clear race: req3 served before req2
    set_req(2, 2'b10, 34'h99);
    set_req(3, 2'b00, 34'h1234);
    step();
    step();
    chk("race.src1", WIDTH'(rd_src), WIDTH'(3));
    chk("race.data1", rd_data, 34'h1234);
    chk("race.rdy1", WIDTH'(req_ready), WIDTH'(4'b1000));
    req_valid[3] = 1'b0;
    step();
    step();
    step();
    chk("race.src2", WIDTH'(rd_src), WIDTH'(2));
    chk("race.data2", rd_data, '0);
    chk("race.regq2", reg_q, '0);
    req_valid[2] = 1'b0;
    step();

    // load something nonzero, then reset during EXEC
    do_op("preabc", 0, 2'b00, 34'h1, 34'h1);
    set_req(1, 2'b00, 34'hABC);
    step();
    chk("mid.busy", WIDTH'(busy), WIDTH'(1));
    chk("mid.regd", reg_d, 34'hABC);
    Rn = 1'b0;
    #1;
    chk("mid.regd_rst", reg_d, '0);
    chk("mid.busy_rst", WIDTH'(busy), '0);
    step();
    chk("mid.regq", reg_q, '0);
    chk("mid.rdy", WIDTH'(req_ready), '0);
    chk("mid.vld", WIDTH'(rd_valid), '0);
    req_valid = '0;
    Rn = 1'b1;
    step();
    chk("mid.rdy2", WIDTH'(req_ready), '0);
    chk("mid.idle", WIDTH'(busy), '0);
    chk("mid.hold", reg_q, '0);

    // ptr back at 0 after reset: req0 read sees 0
    do_op("postrst", 0, 2'b11, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
